// File: rtl/reciprocal.sv
// Sequential fixed-point reciprocal unit for the white-balance datapath.
// Produces floor(2^OUT_W / avg) with a restoring radix-2 divider that retires
// one quotient bit per clock. Quotients that do not fit OUT_W bits (avg of 0
// or 1) saturate to all-ones. Latency is always OUT_W+1 cycles after accept.
module reciprocal #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  avg,
  output logic             busy,
  output logic             out_valid,
  output logic [OUT_W-1:0] recip
);

  localparam int CNT_W = $clog2(OUT_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(OUT_W);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  state_e           state_q, state_d;
  logic [IN_W-1:0]  divisor_q, divisor_d;
  logic [IN_W:0]    rem_q, rem_d;
  logic [OUT_W:0]   quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] recip_q, recip_d;

  logic             dividendBit;
  logic [IN_W:0]    remShift;
  logic [IN_W:0]    divisorExt;
  logic             qBit;
  logic [IN_W:0]    remNext;
  logic [OUT_W:0]   quoNext;
  logic [OUT_W-1:0] quoSat;

  // One restoring-division step: shift in the next dividend bit, trial-subtract, keep or restore.
  always_comb begin
    dividendBit = 1'b0;
    remShift    = '0;
    divisorExt  = '0;
    qBit        = 1'b0;
    remNext     = '0;
    quoNext     = '0;
    quoSat      = '0;

    // The dividend 2^OUT_W has a single 1 in its MSB, which is consumed on the first step.
    dividendBit = (cnt_q == '0);
    remShift    = {rem_q[IN_W-1:0], dividendBit};
    divisorExt  = {1'b0, divisor_q};
    // A bit shifted out of the remainder means the true value exceeds any possible divisor.
    qBit        = rem_q[IN_W] | (remShift >= divisorExt);
    remNext     = qBit ? (remShift - divisorExt) : remShift;
    quoNext     = {quo_q[OUT_W-1:0], qBit};
    // Divide by zero yields all-ones bits anyway; avg==1 sets the overflow bit.
    quoSat      = quoNext[OUT_W] ? '1 : quoNext[OUT_W-1:0];
  end

  // Control FSM: accept a request when idle, iterate OUT_W+1 times, then publish the result.
  always_comb begin
    state_d     = state_q;
    divisor_d   = divisor_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    recip_d     = recip_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d   = ST_RUN;
          divisor_d = avg;
          rem_d     = '0;
          quo_d     = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
        end
      end
      ST_RUN: begin
        rem_d = remNext;
        quo_d = quoNext;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          recip_d     = quoSat;
          cnt_d       = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any running division without a result pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      divisor_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      recip_q     <= '0;
    end else begin
      state_q     <= state_d;
      divisor_q   <= divisor_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      recip_q     <= recip_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign recip     = recip_q;

endmodule

// File: tb/tb_reciprocal.sv
// Directed self-checking bench for the reciprocal unit: reset behaviour,
// known quotients, saturation, busy-drop with operand capture, mid-run reset
// and a back-to-back sweep of every 8-bit average.
module tb_reciprocal;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  avg;
  logic        busy;
  logic        out_valid;
  logic [31:0] recip;

  int checkCount;
  int errorCount;

  reciprocal #(
    .IN_W(8),
    .OUT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .avg(avg),
    .busy(busy),
    .out_valid(out_valid),
    .recip(recip)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference: 2^32/avg clamped to 32 bits, all-ones for avg of zero.
  function automatic logic [31:0] recipModel(input int a);
    logic [63:0] q;
    if (a == 0) return 32'hFFFF_FFFF;
    q = (64'd1 << 32) / 64'(a);
    if (q > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
    return q[31:0];
  endfunction

  // Waits for the result pulse; lat is the edge count after the accept edge, 99 if it never comes.
  task automatic waitDone(output int lat);
    lat = 99;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  // Single request with a hand-computed expected reciprocal; avg is scrambled after accept.
  task automatic applyStimulus(input logic [7:0] a, input logic [31:0] expected, input string tag);
    int lat;
    @(negedge clk);
    avg      = a;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    avg      = ~a;
    checkOutput({tag, " busy after accept"}, 32'(busy), 32'd1);
    waitDone(lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'd33);
    checkOutput({tag, " recip"}, recip, expected);
    checkOutput({tag, " busy at done"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, " pulse width"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " recip hold"}, recip, expected);
  endtask

  initial begin
    int pulses;
    int firstAt;
    logic [31:0] firstVal;
    int lat;

    checkCount = 0;
    errorCount = 0;

    // Reset with a simultaneous request: nothing may start.
    rst      = 1'b1;
    in_valid = 1'b1;
    avg      = 8'd9;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset recip", recip, 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post-reset idle", 32'(busy), 32'd0);

    // Known quotients.
    applyStimulus(8'd2,   32'h8000_0000, "avg2");
    applyStimulus(8'd3,   32'h5555_5555, "avg3");
    applyStimulus(8'd7,   32'h2492_4924, "avg7");
    applyStimulus(8'd128, 32'h0200_0000, "avg128");
    applyStimulus(8'd255, 32'h0101_0101, "avg255");

    // Saturation cases.
    applyStimulus(8'd1, 32'hFFFF_FFFF, "avg1 sat");
    applyStimulus(8'd0, 32'hFFFF_FFFF, "avg0 sat");

    // Busy drop and operand capture: a second request mid-run must vanish.
    @(negedge clk);
    avg      = 8'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pulses   = 0;
    firstAt  = 0;
    firstVal = '0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk);
      #1;
      if (n == 10) begin
        avg      = 8'd10;
        in_valid = 1'b1;
      end
      if (n == 11) in_valid = 1'b0;
      if (out_valid) begin
        if (pulses == 0) begin
          firstAt  = n;
          firstVal = recip;
        end
        pulses++;
      end
    end
    checkOutput("drop pulse count", 32'(pulses), 32'd1);
    checkOutput("drop latency", 32'(firstAt), 32'd33);
    checkOutput("drop recip", firstVal, 32'h3333_3333);
    checkOutput("drop recip hold", recip, 32'h3333_3333);
    checkOutput("drop busy idle", 32'(busy), 32'd0);

    // Reset in the middle of a division.
    @(negedge clk);
    avg      = 8'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pulses   = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (n == 10) rst = 1'b1;
      if (n == 11) begin
        rst = 1'b0;
        checkOutput("midreset recip", recip, 32'd0);
        checkOutput("midreset busy", 32'(busy), 32'd0);
      end
      if (out_valid) pulses++;
    end
    checkOutput("midreset no pulse", 32'(pulses), 32'd0);
    checkOutput("midreset recip hold", recip, 32'd0);
    applyStimulus(8'd4, 32'h4000_0000, "after reset avg4");

    // Back-to-back sweep with in_valid held high.
    @(negedge clk);
    avg      = 8'd0;
    in_valid = 1'b1;
    for (int v = 0; v < 256; v++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("sweep %0d accept", v), 32'(busy), 32'd1);
      avg = ~8'(v);
      waitDone(lat);
      checkOutput($sformatf("sweep %0d latency", v), 32'(lat), 32'd33);
      checkOutput($sformatf("sweep %0d recip", v), recip, recipModel(v));
      checkOutput($sformatf("sweep %0d busy at done", v), 32'(busy), 32'd0);
      avg = 8'(v + 1);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("sweep end idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
